csa_accum_ctrl: RTL and testbench
=================================

Name: csa_accum_ctrl

Overview:
- Frame-based multi-operand accumulator controller built around one shared csa3_2 carry-save stage.
- Each accepted operand is folded into a redundant (sum, carry) pair, one operand per cycle.
- On the frame's last operand, the pair is resolved to binary by a chunked carry-propagate adder, CHUNK bits per cycle.
- Feeds bucket/partial-sum reduction in the MSM datapath, where long operand streams must not hit a full-width CPA every cycle.

Parameters:
- W, 27: operand width in bits (matches the csa3_2 CSAWIDTH default).
- GUARD, 5: guard bits; ACCW = W+GUARD is the accumulator and result width.
- CHUNK, 8: CPA slice width per resolve cycle; ACCW % CHUNK must equal 0; NCHUNK = ACCW/CHUNK.

Ports:
- clk  in  1  clock.
- rstN  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  controller can accept a beat.
- in_data  in  W  operand, zero-extended to ACCW.
- in_last  in  1  beat is the final operand of the frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACCW  frame sum mod 2^ACCW.
- out_ovf  out  1  frame had more than 2^GUARD beats.
- busy  out  1  high in any state other than IDLE with empty frame.

Behaviour:
- One clock domain. rstN is sampled only on a rising clk edge. There is no asynchronous path.
- Reset values:
  - state = ACCUM;
  - sum_r = 0, car_r = 0;
  - cnt = 0 (GUARD+1 bits, saturating);
  - in_ready = 1, out_valid = 0, out_data = 0, out_ovf = 0, busy = 0.
- States: ACCUM, RESOLVE, HOLD.
- ACCUM:
  - in_ready = 1.
  - A beat is accepted on an edge where in_valid and in_ready are both high.
  - Accepted beat: the CSA inputs are (sum_r, car_r, zext(in_data)) producing (s, co). Then sum_r <= s and car_r <= {co[ACCW-2:0], 0}. The carry MSB is discarded, so arithmetic is mod 2^ACCW.
  - cnt increments on each accepted beat and saturates at 2^GUARD+1.
  - busy = (cnt != 0).
  - Accepted beat with in_last = 1: the update above still applies, then go to RESOLVE with chunk index k = 0 and carry-in cy = 0.
  - in_valid without in_ready, or in_ready without in_valid: no change.
- RESOLVE:
  - in_ready = 0, busy = 1.
  - On each edge, slice k computes sum_r[k] + car_r[k] + cy. The result goes to res_r[k], and the carry-out goes to cy.
  - k increments on each edge.
  - After NCHUNK edges, go to HOLD with out_data = res_r and out_ovf = (cnt > 2^GUARD).
  - Final carry-out is discarded.
- Latency: last beat accepted on edge t; out_valid is first observed high after edge t+NCHUNK+1 (t+5 at defaults).
- HOLD:
  - out_valid = 1, in_ready = 0.
  - out_data and out_ovf are held stable while out_ready is low.
  - Handshake edge (out_valid and out_ready both high): out_valid <= 0; clear sum_r, car_r, cnt and res_r; return to ACCUM.
  - in_ready = 1 on the cycle after the handshake, giving one bubble per frame.
- Beats presented while in_ready = 0 are not consumed; the producer must hold them.
- A single-beat frame (in_last on the first beat) is legal. The result is zext(in_data).
- An empty frame is impossible, because a frame begins with an accepted beat.
- Overflow: the result wraps mod 2^ACCW. out_ovf is informational only and is sticky per frame via saturating cnt.
- Reset in any state (including mid-RESOLVE or HOLD with out_valid high): on that edge, return to reset values. The partial frame is lost and no out_valid pulse is produced.
- Simultaneous rstN low and a handshake on the same edge: reset wins.

Test Plan (W=27, GUARD=5, CHUNK=8, ACCW=32):
- Single beat 0x0000005 with in_last, out_ready held high -> out_valid high after edge t+5, out_data = 0x00000005, out_ovf = 0, in_ready = 1 on the following cycle.
- Three beats of 0x7FFFFFF, last on the third -> out_data = 0x17FFFFFD, out_ovf = 0. Repeat with in_valid gaps of 0–3 cycles between beats -> identical result.
- Boundary frames of 0x7FFFFFF:
  - 32 beats -> out_data = 0xFFFFFFE0, out_ovf = 0.
  - 33 beats -> out_data = 0x07FFFFDF, out_ovf = 1.
- Backpressure: complete the 3-beat frame, hold out_ready = 0 for 10 cycles while driving in_valid = 1 with 0x1234567 -> out_valid stays high, out_data stays stable, in_ready = 0, no beat consumed. After the handshake, that beat starts the next frame.
- Reset mid-RESOLVE: assert rstN = 0 for one edge two cycles after the last beat -> all outputs return to reset values, no out_valid. The next frame (beat 0x0000009, last) yields 0x00000009.
- Back-to-back frames, in_valid continuously high: frame A = {1, 2, 3}, frame B = {0x7FFFFFF} -> results 0x00000006 then 0x07FFFFFF, with no cross-frame contamination and exactly one idle bubble after each handshake.

Source files
------------

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: frame-based multi-operand accumulator.
// Operands are folded into a redundant (sum, carry) pair through a single
// 3:2 carry-save stage, one per cycle. On the last operand of a frame the pair
// is resolved to binary by a CHUNK-wide carry-propagate adder, one slice per
// cycle, then held until the consumer takes it.
module csa_accum_ctrl #(
  parameter int W     = 27,
  parameter int GUARD = 5,
  parameter int CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W+GUARD-1:0]   out_data,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int ACCW   = W + GUARD;
  localparam int NCHUNK = ACCW / CHUNK;
  localparam int KW     = $clog2(NCHUNK + 1);
  localparam int CW     = GUARD + 1;
  localparam logic [CW-1:0] CNT_OVF = CW'(2 ** GUARD);
  localparam logic [CW-1:0] CNT_SAT = CW'(2 ** GUARD + 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACCW-1:0]   sum_q, sum_d;
  logic [ACCW-1:0]   car_q, car_d;
  logic [ACCW-1:0]   res_q, res_d;
  logic [ACCW-1:0]   out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic              cy_q, cy_d;

  logic [ACCW-1:0]   op_zext;
  logic [ACCW-1:0]   csa_s;
  logic [ACCW-1:0]   csa_co;
  logic [CHUNK-1:0]  sl_s;
  logic [CHUNK-1:0]  sl_c;
  logic [CHUNK:0]    sl_add;

  // Shared 3:2 carry-save stage: folds the incoming operand into (sum, carry).
  always_comb begin
    op_zext = {{GUARD{1'b0}}, in_data};
    csa_s   = sum_q ^ car_q ^ op_zext;
    csa_co  = (sum_q & car_q) | (sum_q & op_zext) | (car_q & op_zext);
  end

  // One CPA slice: selects chunk k of the redundant pair and adds the running carry.
  always_comb begin
    sl_s = '0;
    sl_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        sl_s = sum_q[i*CHUNK +: CHUNK];
        sl_c = car_q[i*CHUNK +: CHUNK];
      end
    end
    sl_add = {1'b0, sl_s} + {1'b0, sl_c} + {{CHUNK{1'b0}}, cy_q};
  end

  // Next-state logic for the accumulate / resolve / hold sequence.
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    car_d      = car_q;
    res_d      = res_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    cy_d       = cy_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          sum_d = csa_s;
          // Carry MSB falls off the top: accumulation is mod 2^ACCW.
          car_d = {csa_co[ACCW-2:0], 1'b0};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
          if (in_last) begin
            state_d = RESOLVE;
            k_d     = '0;
            cy_d    = 1'b0;
          end
        end
      end
      RESOLVE: begin
        if (k_q == KW'(NCHUNK)) begin
          // All slices done: publish the result; the final carry-out is dropped.
          out_data_d = res_q;
          out_ovf_d  = (cnt_q > CNT_OVF);
          state_d    = HOLD;
        end else begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (k_q == KW'(i)) res_d[i*CHUNK +: CHUNK] = sl_add[CHUNK-1:0];
          end
          cy_d = sl_add[CHUNK];
          k_d  = k_q + KW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          sum_d   = '0;
          car_d   = '0;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q    <= ACCUM;
      sum_q      <= '0;
      car_q      <= '0;
      res_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      cnt_q      <= '0;
      k_q        <= '0;
      cy_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      car_q      <= car_d;
      res_q      <= res_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      cy_q       <= cy_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != ACCUM) || (cnt_q != '0);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed testbench for csa_accum_ctrl at W=27, GUARD=5, CHUNK=8 (ACCW=32).
module tb_csa_accum_ctrl;

  logic        clk;
  logic        rstN;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  csa_accum_ctrl #(.W(27), .GUARD(5), .CHUNK(8)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat after 'gap' idle cycles; returns just after its accept edge.
  task automatic send_beat(input logic [26:0] d, input logic last, input int gap, output bit to);
    int n;
    to = 1'b0;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) to = 1'b1;
    else step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Count edges until out_valid is observed high (bounded).
  task automatic wait_out(output int n, output bit to);
    n  = 0;
    to = 1'b0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    if (!out_valid) to = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    step();
    step();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
    total++; if (out_ovf !== 1'b0)   begin bad++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rstN = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit to;
    int n;
    out_ready = 1'b1;
    send_beat(27'h0000005, 1'b1, 0, to);
    total++; if (to) begin bad++; $display("FAIL single_accept got=timeout exp=accepted"); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_out(n, to);
    total++; if (to || n != 5) begin bad++; $display("FAIL single_latency got=%0d exp=5", n); end
    total++; if (out_data !== 32'h00000005) begin bad++; $display("FAIL single_data got=%h exp=00000005", out_data); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf got=%b exp=0", out_ovf); end
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL single_after_hs got=v%b r%b exp=v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_three_gaps();
    bit to;
    int n;
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      send_beat(27'h7FFFFFF, 1'b0, g, to);
      send_beat(27'h7FFFFFF, 1'b0, g, to);
      send_beat(27'h7FFFFFF, 1'b1, g, to);
      wait_out(n, to);
      total++; if (to || out_data !== 32'h17FFFFFD) begin bad++; $display("FAIL three_gap%0d_data got=%h exp=17FFFFFD", g, out_data); end
      total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL three_gap%0d_ovf got=%b exp=0", g, out_ovf); end
      step();
    end
  endtask

  task automatic test_boundary();
    bit to;
    int n;
    out_ready = 1'b1;
    for (int b = 0; b < 32; b++) send_beat(27'h7FFFFFF, (b == 31), 0, to);
    wait_out(n, to);
    total++; if (to || out_data !== 32'hFFFFFFE0) begin bad++; $display("FAIL bound32_data got=%h exp=FFFFFFE0", out_data); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL bound32_ovf got=%b exp=0", out_ovf); end
    step();
    for (int b = 0; b < 33; b++) send_beat(27'h7FFFFFF, (b == 32), 0, to);
    wait_out(n, to);
    total++; if (to || out_data !== 32'h07FFFFDF) begin bad++; $display("FAIL bound33_data got=%h exp=07FFFFDF", out_data); end
    total++; if (out_ovf !== 1'b1) begin bad++; $display("FAIL bound33_ovf got=%b exp=1", out_ovf); end
    step();
  endtask

  task automatic test_backpressure();
    bit to;
    int n;
    int errs;
    out_ready = 1'b0;
    send_beat(27'h7FFFFFF, 1'b0, 0, to);
    send_beat(27'h7FFFFFF, 1'b0, 0, to);
    send_beat(27'h7FFFFFF, 1'b1, 0, to);
    wait_out(n, to);
    total++; if (to || n != 5) begin bad++; $display("FAIL bp_latency got=%0d exp=5", n); end
    in_valid = 1'b1;
    in_data  = 27'h1234567;
    in_last  = 1'b1;
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid !== 1'b1 || out_data !== 32'h17FFFFFD || in_ready !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold got=%0d_bad_cycles exp=0 (v%b d%h r%b)", errs, out_valid, out_data, in_ready); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_hs got=v%b r%b exp=v0 r1", out_valid, in_ready); end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out(n, to);
    total++; if (to || n != 5) begin bad++; $display("FAIL bp_next_latency got=%0d exp=5", n); end
    total++; if (out_data !== 32'h01234567) begin bad++; $display("FAIL bp_next_data got=%h exp=01234567", out_data); end
    step();
  endtask

  task automatic test_reset_mid();
    bit to;
    bit seen;
    int n;
    out_ready = 1'b1;
    send_beat(27'h0000011, 1'b0, 0, to);
    send_beat(27'h0000022, 1'b1, 0, to);
    step();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_ctrl got=r%b v%b b%b exp=r1 v0 b0", in_ready, out_valid, busy); end
    total++; if (out_data !== 32'h0 || out_ovf !== 1'b0) begin bad++; $display("FAIL rmid_data got=%h/%b exp=00000000/0", out_data, out_ovf); end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rmid_no_valid got=1 exp=0"); end
    send_beat(27'h0000009, 1'b1, 0, to);
    wait_out(n, to);
    total++; if (to || out_data !== 32'h00000009) begin bad++; $display("FAIL rmid_next_data got=%h exp=00000009", out_data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [26:0] bd [4];
    logic        bl [4];
    int          acc_edge [4];
    logic [31:0] res [2];
    int idx, cyc, nres;
    bit rdy;
    bd[0] = 27'h0000001; bl[0] = 1'b0;
    bd[1] = 27'h0000002; bl[1] = 1'b0;
    bd[2] = 27'h0000003; bl[2] = 1'b1;
    bd[3] = 27'h7FFFFFF; bl[3] = 1'b1;
    for (int i = 0; i < 4; i++) acc_edge[i] = 0;
    res[0] = '0;
    res[1] = '0;
    idx = 0; cyc = 0; nres = 0;
    out_ready = 1'b1;
    while (cyc < 60 && (idx < 4 || nres < 2)) begin
      if (idx < 4) begin
        in_valid = 1'b1;
        in_data  = bd[idx];
        in_last  = bl[idx];
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      rdy = in_ready;
      step();
      cyc++;
      if (rdy && in_valid && idx < 4) begin
        acc_edge[idx] = cyc;
        idx++;
      end
      if (out_valid && nres < 2) begin
        res[nres] = out_data;
        nres++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++; if (nres != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", nres); end
    total++; if (res[0] !== 32'h00000006) begin bad++; $display("FAIL b2b_frameA got=%h exp=00000006", res[0]); end
    total++; if (res[1] !== 32'h07FFFFFF) begin bad++; $display("FAIL b2b_frameB got=%h exp=07FFFFFF", res[1]); end
    total++; if (acc_edge[1] - acc_edge[0] != 1 || acc_edge[2] - acc_edge[1] != 1) begin bad++; $display("FAIL b2b_stream got=%0d,%0d exp=1,1", acc_edge[1] - acc_edge[0], acc_edge[2] - acc_edge[1]); end
    total++; if (acc_edge[3] - acc_edge[2] != 7) begin bad++; $display("FAIL b2b_bubble got=%0d exp=7", acc_edge[3] - acc_edge[2]); end
    step();
  endtask

  initial begin
    rstN      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_three_gaps();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
